// File: rtl/register64.sv
// WIDTH-bit load-enable storage register with synchronous active-low reset.
// Optional registered even-parity output when REGISTER64_PARITY_EN is defined.
module register64 #(
   parameter int unsigned      WIDTH       = 64,
   parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
   output logic [WIDTH-1:0] data_out,
   input  logic [WIDTH-1:0] data_in,
   input  logic             clk,
   input  logic             reset,
   input  logic             write_en
`ifdef REGISTER64_PARITY_EN
   ,
   output logic             data_parity
`endif
);

   logic [WIDTH-1:0] data_next;

   // Per-bit enable mux in front of each flop; hold recirculates the stored bit.
   // NOTE: always_comb gives every output a value on every path, so no latch is inferred.
   always_comb begin
      data_next = data_out;
      for (int i = 0; i < int'(WIDTH); i++) begin
         data_next[i] = write_en ? data_in[i] : data_out[i];
      end
   end

`ifdef REGISTER64_PARITY_EN
   logic parity_next;

   always_comb begin
      parity_next = write_en ? ^data_in : data_parity;
   end

   // Parity is tracked alongside the data so it always matches ^data_out.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep flop updates order-independent.
      if (!reset) begin
         data_out    <= RESET_VALUE;
         data_parity <= ^RESET_VALUE;
      end else begin
         data_out    <= data_next;
         data_parity <= parity_next;
      end
   end
`else
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments keep flop updates order-independent.
      if (!reset) begin
         data_out <= RESET_VALUE;
      end else begin
         data_out <= data_next;
      end
   end
`endif

endmodule

// File: tb/tb_register64.sv
// Self-checking bench for register64: directed vector table, sync-reset timing
// sequences and randomized traffic against a behavioural model.
module tb_register64;

   localparam int W = 64;

   logic [W-1:0] data_out;
   logic [W-1:0] data_in;
   logic         clk;
   logic         reset;
   logic         write_en;
`ifdef REGISTER64_PARITY_EN
   logic         data_parity;
`endif

   int tests_run = 0;
   int tests_failed = 0;

   register64 #(.WIDTH(W)) dut (
      .data_out (data_out),
      .data_in  (data_in),
      .clk      (clk),
      .reset    (reset),
      .write_en (write_en)
`ifdef REGISTER64_PARITY_EN
      ,
      .data_parity (data_parity)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      string        name;
      logic         rst_n;
      logic         we;
      logic [W-1:0] din;
      logic [W-1:0] exp;
   } vec_t;

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_parity(input string name, input logic [W-1:0] exp_data);
`ifdef REGISTER64_PARITY_EN
      tests_run++;
      if (data_parity !== ^exp_data) begin
         tests_failed++;
         $display("FAIL %s parity: got %b expected %b", name, data_parity, ^exp_data);
      end
`else
      if (exp_data === 'x) $display("unused");
`endif
   endtask

   // Drive on the falling edge, let the rising edge capture, sample 1 ns later.
   task automatic apply(input logic r, input logic we, input logic [W-1:0] din);
      @(negedge clk);
      reset    = r;
      write_en = we;
      data_in  = din;
      @(posedge clk);
      #1;
   endtask

   vec_t         vecs[$];
   logic [W-1:0] model;
   logic [W-1:0] rnd;
   logic         r_rst, r_we;

   initial begin
      reset    = 1'b0;
      write_en = 1'b0;
      data_in  = '0;

      vecs.push_back('{"reset_dominates", 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0});
      vecs.push_back('{"load",            1'b1, 1'b1, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF});
      for (int i = 0; i < 5; i++)
         vecs.push_back('{"hold",         1'b1, 1'b0, 64'hDEAD_BEEF_0000_0001, 64'h0123_4567_89AB_CDEF});
      vecs.push_back('{"b2b_7",           1'b1, 1'b1, 64'd7,   64'd7});
      vecs.push_back('{"b2b_127",         1'b1, 1'b1, 64'd127, 64'd127});
      vecs.push_back('{"b2b_0",           1'b1, 1'b1, 64'd0,   64'd0});
      vecs.push_back('{"load_ones",       1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF});
      vecs.push_back('{"reset_no_we",     1'b0, 1'b0, 64'h5555_5555_5555_5555, 64'h0});

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].name == "load") begin
            // Load must not be visible before the capturing edge.
            @(negedge clk);
            reset    = vecs[i].rst_n;
            write_en = vecs[i].we;
            data_in  = vecs[i].din;
            #2;
            check("load_not_early", data_out, 64'h0);
            @(posedge clk);
            #1;
         end else begin
            apply(vecs[i].rst_n, vecs[i].we, vecs[i].din);
         end
         check(vecs[i].name, data_out, vecs[i].exp);
         check_parity(vecs[i].name, vecs[i].exp);
      end

      // Reset pulse entirely between edges must be ignored.
      apply(1'b1, 1'b1, 64'hA5A5_0000_FFFF_1234);
      check("preload", data_out, 64'hA5A5_0000_FFFF_1234);
      @(negedge clk);
      write_en = 1'b0;
      reset    = 1'b0;
      #2;
      reset    = 1'b1;
      @(posedge clk);
      #1;
      check("glitch_reset_ignored", data_out, 64'hA5A5_0000_FFFF_1234);
      // Reset held across an edge clears the register.
      @(negedge clk);
      reset = 1'b0;
      #2;
      check("reset_not_async", data_out, 64'hA5A5_0000_FFFF_1234);
      @(posedge clk);
      #1;
      check("reset_held_edge", data_out, 64'h0);
      check_parity("reset_held_edge", 64'h0);

      // Randomized traffic against a behavioural model.
      model = '0;
      for (int c = 0; c < 1000; c++) begin
         r_rst = ($urandom_range(0, 49) == 0) ? 1'b0 : 1'b1;
         r_we  = $urandom_range(0, 1) == 1;
         if (c % 2 == 0) rnd = 64'($urandom_range(0, 127));
         else            rnd = {$urandom, $urandom};
         apply(r_rst, r_we, rnd);
         if (!r_rst)    model = '0;
         else if (r_we) model = rnd;
         check("random", data_out, model);
         check_parity("random", model);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
